// File: rtl/vliw_fetch_stage_if.sv
// Bundle fetch bus between the VLIW fetch stage and its environment:
// hazard-unit controls, instruction memory port and the IF/ID outputs.
interface vliw_fetch_stage_if #(
  parameter int PC_W    = 32,
  parameter int INSTR_W = 32
);
  logic                 pc_write;
  logic                 if_id_write;
  logic                 flush;
  logic [PC_W-1:0]      redirect_pc;
  logic                 imem_en;
  logic [PC_W-1:0]      imem_addr;
  logic [2*INSTR_W-1:0] imem_rdata;
  logic [INSTR_W-1:0]   if_id_instr1;
  logic [INSTR_W-1:0]   if_id_instr2;
  logic [PC_W-1:0]      if_id_pc;
  logic                 if_id_valid;
  logic                 protocol_err;

  // The fetch stage: issues memory reads and drives the IF/ID register.
  modport master (
    input  pc_write, if_id_write, flush, redirect_pc, imem_rdata,
    output imem_en, imem_addr, if_id_instr1, if_id_instr2, if_id_pc,
           if_id_valid, protocol_err
  );

  // The surroundings: hazard unit, instruction memory and decode.
  modport slave (
    output pc_write, if_id_write, flush, redirect_pc, imem_rdata,
    input  imem_en, imem_addr, if_id_instr1, if_id_instr2, if_id_pc,
           if_id_valid, protocol_err
  );
endinterface

// File: rtl/vliw_fetch_stage.sv
// Two-slot VLIW fetch stage with IF/ID pipeline register.
// Memory reads return one cycle after issue; a one-entry skid buffer
// catches the response that lands while decode is stalled, so bundles
// reach IF/ID in order with no loss or duplication. A flush redirects
// fetch and discards everything still in flight.
module vliw_fetch_stage #(
  parameter int              PC_W     = 32,
  parameter int              INSTR_W  = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  vliw_fetch_stage_if.master  bus
);

  localparam logic [PC_W-1:0] BUNDLE_BYTES = PC_W'(8);
  localparam logic [PC_W-1:0] ALIGN_MASK   = ~PC_W'(7);

  logic [PC_W-1:0]      pc_q;
  logic                 resp_valid;
  logic [PC_W-1:0]      resp_pc;
  logic                 skid_valid;
  logic [PC_W-1:0]      skid_pc;
  logic [2*INSTR_W-1:0] skid_data;
  logic [INSTR_W-1:0]   instr1_q;
  logic [INSTR_W-1:0]   instr2_q;
  logic [PC_W-1:0]      if_id_pc_q;
  logic                 if_id_valid_q;
  logic                 protocol_err_q;

  logic [PC_W-1:0]      aligned_redirect;
  logic                 src_valid;
  logic [PC_W-1:0]      src_pc;
  logic [2*INSTR_W-1:0] src_data;
  logic                 mismatch;

  assign aligned_redirect = bus.redirect_pc & ALIGN_MASK;
  assign mismatch         = bus.pc_write ^ bus.if_id_write;

  assign bus.imem_en      = rst_n & (bus.pc_write | bus.flush);
  assign bus.imem_addr    = bus.flush ? aligned_redirect : pc_q;

  assign bus.if_id_instr1 = instr1_q;
  assign bus.if_id_instr2 = instr2_q;
  assign bus.if_id_pc     = if_id_pc_q;
  assign bus.if_id_valid  = if_id_valid_q;
  assign bus.protocol_err = protocol_err_q;

  // Pick the bundle for IF/ID: an older skid entry beats the fresh response.
  always_comb begin
    src_valid = 1'b0;
    src_pc    = resp_pc;
    src_data  = bus.imem_rdata;
    if (skid_valid) begin
      src_valid = 1'b1;
      src_pc    = skid_pc;
      src_data  = skid_data;
    end else if (resp_valid) begin
      src_valid = 1'b1;
    end
  end

  // PC, response tracking, skid buffer, IF/ID register and sticky error.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q           <= RESET_PC;
      resp_valid     <= 1'b0;
      resp_pc        <= '0;
      skid_valid     <= 1'b0;
      skid_pc        <= '0;
      skid_data      <= '0;
      instr1_q       <= '0;
      instr2_q       <= '0;
      if_id_pc_q     <= '0;
      if_id_valid_q  <= 1'b0;
      protocol_err_q <= 1'b0;
    end else begin
      if (bus.flush) begin
        pc_q <= aligned_redirect + BUNDLE_BYTES;
      end else if (bus.pc_write) begin
        pc_q <= pc_q + BUNDLE_BYTES;
      end

      resp_valid <= bus.imem_en;
      resp_pc    <= bus.imem_addr;

      if (bus.flush) begin
        if_id_valid_q <= 1'b0;
        skid_valid    <= 1'b0;
      end else begin
        if (mismatch) begin
          protocol_err_q <= 1'b1;
        end
        if (bus.if_id_write) begin
          if_id_valid_q <= src_valid;
          if (src_valid) begin
            instr1_q   <= src_data[INSTR_W-1:0];
            instr2_q   <= src_data[2*INSTR_W-1:INSTR_W];
            if_id_pc_q <= src_pc;
          end
          if (skid_valid && resp_valid) begin
            skid_valid <= 1'b1;
            skid_pc    <= resp_pc;
            skid_data  <= bus.imem_rdata;
          end else begin
            skid_valid <= 1'b0;
          end
        end else if (resp_valid) begin
          if (!skid_valid) begin
            skid_valid <= 1'b1;
            skid_pc    <= resp_pc;
            skid_data  <= bus.imem_rdata;
          end else begin
            protocol_err_q <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_vliw_fetch_stage.sv
// Directed bench for vliw_fetch_stage. The memory model answers a read of
// address A one cycle later with {A+4, A}, so slot 1 of a bundle equals its
// PC and slot 2 equals PC+4; idle cycles return a poison pattern.
module tb_vliw_fetch_stage;

  typedef struct {
    logic        pw;
    logic        iw;
    logic        fl;
    logic [31:0] redir;
    logic        exp_en;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
  } vec_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   passes;
  vec_t vecs[12];

  vliw_fetch_stage_if #(.PC_W(32), .INSTR_W(32)) bus ();

  vliw_fetch_stage #(.PC_W(32), .INSTR_W(32), .RESET_PC(32'h0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous instruction memory with one-cycle read latency.
  always @(posedge clk) begin
    if (bus.imem_en) bus.imem_rdata <= {bus.imem_addr + 32'd4, bus.imem_addr};
    else             bus.imem_rdata <= {2{32'hDEAD_BEEF}};
  end

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    else passes++;
  endtask

  // One clock cycle: drive inputs at the falling edge, check the memory
  // port before the rising edge and the IF/ID register just after it.
  task automatic apply_stimulus(input logic r, input logic pw, input logic iw, input logic fl,
                                input logic [31:0] redir, input logic exp_en,
                                input logic [31:0] exp_addr, input logic exp_valid,
                                input logic [31:0] exp_pc, input logic exp_err, input string tag);
    @(negedge clk);
    rst_n           = r;
    bus.pc_write    = pw;
    bus.if_id_write = iw;
    bus.flush       = fl;
    bus.redirect_pc = redir;
    #1;
    check_output({tag, " imem_en"}, 64'(bus.imem_en), 64'(exp_en));
    if (exp_en) check_output({tag, " imem_addr"}, 64'(bus.imem_addr), 64'(exp_addr));
    @(posedge clk);
    #1;
    check_output({tag, " if_id_valid"}, 64'(bus.if_id_valid), 64'(exp_valid));
    check_output({tag, " protocol_err"}, 64'(bus.protocol_err), 64'(exp_err));
    if (exp_valid) begin
      check_output({tag, " if_id_pc"}, 64'(bus.if_id_pc), 64'(exp_pc));
      check_output({tag, " if_id_instr1"}, 64'(bus.if_id_instr1), 64'(exp_pc));
      check_output({tag, " if_id_instr2"}, 64'(bus.if_id_instr2), 64'(exp_pc + 32'd4));
    end
  endtask

  task automatic check_reset_contents(input string tag);
    check_output({tag, " pc zero"}, 64'(bus.if_id_pc), 64'h0);
    check_output({tag, " instr1 nop"}, 64'(bus.if_id_instr1), 64'h0);
    check_output({tag, " instr2 nop"}, 64'(bus.if_id_instr2), 64'h0);
  endtask

  // Main sequence: reset, table of straight-line/stall/flush vectors, then
  // hand-written corner cases.
  initial begin
    checks          = 0;
    passes          = 0;
    rst_n           = 1'b0;
    bus.pc_write    = 1'b1;
    bus.if_id_write = 1'b1;
    bus.flush       = 1'b0;
    bus.redirect_pc = '0;

    //          pw    iw    fl    redir         en    addr          valid pc
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 32'h0,       1'b1, 32'h0,        1'b0, 32'h0};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 32'h0,       1'b1, 32'h8,        1'b1, 32'h0};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 32'h0,       1'b1, 32'h10,       1'b1, 32'h8};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 32'h0,       1'b0, 32'h0,        1'b1, 32'h8};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 32'h0,       1'b0, 32'h0,        1'b1, 32'h8};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 32'h0,       1'b0, 32'h0,        1'b1, 32'h8};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 32'h0,       1'b1, 32'h18,       1'b1, 32'h10};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 32'h0,       1'b1, 32'h20,       1'b1, 32'h18};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 32'h0,       1'b1, 32'h28,       1'b1, 32'h20};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 32'h103,     1'b1, 32'h100,      1'b0, 32'h0};
    vecs[10] = '{1'b1, 1'b1, 1'b0, 32'h0,       1'b1, 32'h108,      1'b1, 32'h100};
    vecs[11] = '{1'b1, 1'b1, 1'b0, 32'h0,       1'b1, 32'h110,      1'b1, 32'h108};

    apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, "reset0");
    apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, "reset1");
    check_reset_contents("reset");

    for (int i = 0; i < 12; i++) begin
      apply_stimulus(1'b1, vecs[i].pw, vecs[i].iw, vecs[i].fl, vecs[i].redir,
                     vecs[i].exp_en, vecs[i].exp_addr, vecs[i].exp_valid,
                     vecs[i].exp_pc, 1'b0, $sformatf("vec%0d", i));
    end

    // Fetch without decode for two cycles: error latches, IF/ID holds 0x108,
    // skid takes 0x110 and then 0x118 overflows and is dropped.
    apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h118, 1'b1, 32'h108, 1'b1, "perr1");
    apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h120, 1'b1, 32'h108, 1'b1, "perr2");

    // Flush while the skid is full and a response lands: both are discarded.
    apply_stimulus(1'b1, 1'b1, 1'b1, 1'b1, 32'h200, 1'b1, 32'h200, 1'b0, 32'h0, 1'b1, "flush_skid");
    apply_stimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h208, 1'b1, 32'h200, 1'b1, "target0");
    apply_stimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h210, 1'b1, 32'h208, 1'b1, "target1");

    // Stall with skid filled, then reset in the middle of the stall.
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h208, 1'b1, "stall_fill");
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, "mid_reset");
    check_reset_contents("mid_reset");
    apply_stimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0, 1'b0, 32'h0, 1'b0, "restart0");
    apply_stimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h8, 1'b1, 32'h0, 1'b0, "restart1");

    // Redirect to the last bundle of the address space and wrap to zero.
    apply_stimulus(1'b1, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1, 32'hFFFF_FFF8, 1'b0, 32'h0, 1'b0, "wrap_flush");
    apply_stimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0, 1'b1, 32'hFFFF_FFF8, 1'b0, "wrap0");
    apply_stimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h8, 1'b1, 32'h0, 1'b0, "wrap1");
    apply_stimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h10, 1'b1, 32'h8, 1'b0, "wrap2");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
